// File: rtl/fir_coeff_pkg.sv
// ----------------------------------------------------------------------------
// fir_coeff_pkg
// Shared definitions for the FIR coefficient loader: the controller state
// encoding, the coefficient word width and the default BRAM address width.
// No ports.
// ----------------------------------------------------------------------------
package fir_coeff_pkg;

    localparam int WORD_W     = 32;
    localparam int DEF_AWIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_WAIT_SYNC
    } state_t;

endpackage

// File: rtl/coeff_rd_lat_pipe.sv
// ----------------------------------------------------------------------------
// coeff_rd_lat_pipe
// Delay line matching the BRAM port-A read latency. A read issued with
// (i_vld, i_idx) reappears on (o_vld, o_idx) exactly RD_LAT cycles later,
// which is the cycle the matching word sits on the BRAM read-data bus.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, clears every stage
//   i_vld  in   read issued this cycle
//   i_idx  in   word index of the issued read
//   o_vld  out  read data for o_idx is on the BRAM bus this cycle
//   o_idx  out  word index of the returning data
// ----------------------------------------------------------------------------
module coeff_rd_lat_pipe #(
    parameter int RD_LAT = 3,
    parameter int IDXW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_vld,
    input  logic [IDXW-1:0] i_idx,
    output logic            o_vld,
    output logic [IDXW-1:0] o_idx
);

    logic [RD_LAT-1:0]           r_vld_pipe;
    logic [RD_LAT-1:0][IDXW-1:0] r_idx_pipe;

    // Clearing the valids on reset is what throws away reads in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_idx_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= i_vld;
            r_idx_pipe[0] <= i_idx;
            for (int s = 1; s < RD_LAT; s++) begin
                r_vld_pipe[s] <= r_vld_pipe[s-1];
                r_idx_pipe[s] <= r_idx_pipe[s-1];
            end
        end
    end

    assign o_vld = r_vld_pipe[RD_LAT-1];
    assign o_idx = r_idx_pipe[RD_LAT-1];

endmodule

// File: rtl/fir_coeff_loader.sv
// ----------------------------------------------------------------------------
// fir_coeff_loader
// Streams N_WORDS coefficient words out of a BRAM into a shadow register set,
// then swaps the whole set into coeffs_out on an FIR frame boundary so the
// filter never runs with a half-updated coefficient set.
//
// Ports:
//   clk, rst      clock / synchronous active-high reset
//   load_start    single-cycle load request (honoured only when idle)
//   base_addr     first BRAM word address, captured with load_start
//   sync_in       frame boundary pulse; commits a finished load
//   bram_en_a     port-A read enable (high only while issuing addresses)
//   bram_we       port-A write enable, tied low
//   bram_addr     port-A address, (base + i) mod 2^AWIDTH
//   bram_wr_data  port-A write data, tied low
//   bram_rd_data  port-A read data, valid RD_LAT cycles after the address
//   coeffs_out    active coefficients, word k at bits [32k+31:32k]
//   busy          high whenever not idle
//   done          pulses in the cycle the commit happens
//   load_count    number of commits, free-running 16-bit wrap
// ----------------------------------------------------------------------------
module fir_coeff_loader
    import fir_coeff_pkg::*;
#(
    parameter int N_WORDS = 20,
    parameter int RD_LAT  = 3,
    parameter int AWIDTH  = DEF_AWIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic [AWIDTH-1:0]         base_addr,
    input  logic                      sync_in,
    output logic                      bram_en_a,
    output logic                      bram_we,
    output logic [AWIDTH-1:0]         bram_addr,
    output logic [WORD_W-1:0]         bram_wr_data,
    input  logic [WORD_W-1:0]         bram_rd_data,
    output logic [N_WORDS*WORD_W-1:0] coeffs_out,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               load_count
);

    localparam int              IDXW     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_WORDS - 1);

    state_t                           r_state, w_state_nxt;
    logic [AWIDTH-1:0]                r_base;
    logic [IDXW-1:0]                  r_idx;
    logic [N_WORDS-1:0][WORD_W-1:0]   r_shadow;
    logic [N_WORDS-1:0][WORD_W-1:0]   r_coeffs;
    logic [15:0]                      r_load_count;
    logic                             w_issue;
    logic                             w_commit;
    logic                             w_ret_vld;
    logic [IDXW-1:0]                  w_ret_idx;

    assign w_issue = (r_state == ST_READ);

    coeff_rd_lat_pipe #(
        .RD_LAT (RD_LAT),
        .IDXW   (IDXW)
    ) u_lat_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_issue),
        .i_idx  (r_idx),
        .o_vld  (w_ret_vld),
        .o_idx  (w_ret_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE:      if (load_start) w_state_nxt = ST_READ;
            ST_READ:      if (r_idx == LAST_IDX) w_state_nxt = ST_DRAIN;
            // Leave DRAIN on the edge that writes the last word, so the
            // shadow set is complete for the whole of WAIT_SYNC.
            ST_DRAIN:     if (w_ret_vld && (w_ret_idx == LAST_IDX)) w_state_nxt = ST_WAIT_SYNC;
            ST_WAIT_SYNC: if (sync_in) begin
                              w_commit    = 1'b1;
                              w_state_nxt = ST_IDLE;
                          end
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_base       <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_coeffs     <= '0;
            r_load_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && load_start) begin
                r_base <= base_addr;
                r_idx  <= '0;
            end else if (w_issue) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_ret_vld) r_shadow[w_ret_idx] <= bram_rd_data;
            if (w_commit) begin
                r_coeffs     <= r_shadow;
                r_load_count <= r_load_count + 16'd1;
            end
        end
    end

    // Address add truncates to AWIDTH, giving the modulo wrap for free.
    assign bram_addr    = r_base + AWIDTH'(r_idx);
    assign bram_en_a    = w_issue;
    assign bram_we      = 1'b0;
    assign bram_wr_data = '0;
    assign coeffs_out   = r_coeffs;
    assign busy         = (r_state != ST_IDLE);
    assign done         = w_commit;
    assign load_count   = r_load_count;

endmodule

// File: tb/tb_fir_coeff_loader.sv
module tb_fir_coeff_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: N_WORDS=20, instance B: N_WORDS=4 (wrap case)
    logic         ldA, syncA, enA, weA, doneA, busyA;
    logic [9:0]   baseA, addrA;
    logic [31:0]  wdA, rdA;
    logic [639:0] coeffsA;
    logic [15:0]  cntA;

    logic         ldB, syncB, enB, weB, doneB, busyB;
    logic [9:0]   baseB, addrB;
    logic [31:0]  wdB, rdB;
    logic [127:0] coeffsB;
    logic [15:0]  cntB;

    fir_coeff_loader #(.N_WORDS(20), .RD_LAT(3), .AWIDTH(10)) u_dutA (
        .clk(clk), .rst(rst), .load_start(ldA), .base_addr(baseA), .sync_in(syncA),
        .bram_en_a(enA), .bram_we(weA), .bram_addr(addrA), .bram_wr_data(wdA),
        .bram_rd_data(rdA), .coeffs_out(coeffsA), .busy(busyA), .done(doneA),
        .load_count(cntA));

    fir_coeff_loader #(.N_WORDS(4), .RD_LAT(3), .AWIDTH(10)) u_dutB (
        .clk(clk), .rst(rst), .load_start(ldB), .base_addr(baseB), .sync_in(syncB),
        .bram_en_a(enB), .bram_we(weB), .bram_addr(addrB), .bram_wr_data(wdB),
        .bram_rd_data(rdB), .coeffs_out(coeffsB), .busy(busyB), .done(doneB),
        .load_count(cntB));

    // BRAM model: 3-cycle read latency, garbage when not enabled
    logic [31:0] mem [0:1023];
    logic [31:0] a1, a2, b1, b2;
    always @(posedge clk) begin
        a1 <= enA ? mem[addrA] : 32'hDEADBEEF;
        a2 <= a1;
        rdA <= a2;
        b1 <= enB ? mem[addrB] : 32'hDEADBEEF;
        b2 <= b1;
        rdB <= b2;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int addrA_q[$];
    int addrB_q[$];
    int startA, startB, doneA_cyc, doneB_cyc;
    int doneA_cnt = 0, doneB_cnt = 0, wviol = 0;

    always @(negedge clk) begin
        if (ldA) startA = cyc;
        if (ldB) startB = cyc;
        if (doneA) begin doneA_cnt++; doneA_cyc = cyc; end
        if (doneB) begin doneB_cnt++; doneB_cyc = cyc; end
        if (enA) addrA_q.push_back(int'(addrA));
        if (enB) addrB_q.push_back(int'(addrB));
        if (weA !== 1'b0 || wdA !== 32'd0 || weB !== 1'b0 || wdB !== 32'd0) wviol++;
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wA(input int k);
        return coeffsA[32*k +: 32];
    endfunction

    function automatic logic [31:0] wB(input int k);
        return coeffsB[32*k +: 32];
    endfunction

    task automatic pulseA(input logic [9:0] base);
        baseA = base;
        ldA = 1'b1;
        tick();
        ldA = 1'b0;
    endtask

    task automatic wait_doneA(input string tag, input int budget);
        int prev;
        prev = doneA_cnt;
        for (int k = 0; k < budget && doneA_cnt == prev; k++) tick();
        chk(tag, 64'(doneA_cnt - prev), 64'd1);
    endtask

    initial begin
        int prev, bad;
        rst = 1'b1; ldA = 0; syncA = 0; baseA = 0; ldB = 0; syncB = 0; baseB = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_coeffsA_zero", 64'(coeffsA == '0), 64'd1);
        chk("rst_coeffsB_zero", 64'(coeffsB == '0), 64'd1);
        chk("rst_busyA", 64'(busyA), 64'd0);
        chk("rst_doneA", 64'(doneA), 64'd0);
        chk("rst_enA", 64'(enA), 64'd0);
        chk("rst_cntA", 64'(cntA), 64'd0);

        // wrap: base 1022, 4 words
        mem[1022] = 32'hAAAA0001; mem[1023] = 32'hBBBB0002;
        mem[0]    = 32'hCCCC0003; mem[1]    = 32'hDDDD0004;
        syncB = 1'b1; baseB = 10'd1022; ldB = 1'b1;
        tick();
        ldB = 1'b0;
        prev = doneB_cnt;
        for (int k = 0; k < 100 && doneB_cnt == prev; k++) tick();
        chk("wrap_done", 64'(doneB_cnt - prev), 64'd1);
        chk("wrap_latency", 64'(doneB_cyc - startB), 64'd8);
        chk("wrap_naddr", 64'(addrB_q.size()), 64'd4);
        if (addrB_q.size() == 4) begin
            chk("wrap_addr0", 64'(addrB_q[0]), 64'd1022);
            chk("wrap_addr1", 64'(addrB_q[1]), 64'd1023);
            chk("wrap_addr2", 64'(addrB_q[2]), 64'd0);
            chk("wrap_addr3", 64'(addrB_q[3]), 64'd1);
        end
        chk("wrap_w0", 64'(wB(0)), 64'hAAAA0001);
        chk("wrap_w1", 64'(wB(1)), 64'hBBBB0002);
        chk("wrap_w2", 64'(wB(2)), 64'hCCCC0003);
        chk("wrap_w3", 64'(wB(3)), 64'hDDDD0004);
        chk("wrap_cnt", 64'(cntB), 64'd1);
        syncB = 1'b0;

        // basic load: base 0, 20 words, sync held high
        for (int i = 0; i < 20; i++) mem[i] = 32'h1000 + i;
        addrA_q.delete();
        syncA = 1'b1;
        pulseA(10'd0);
        wait_doneA("basic_done", 100);
        chk("basic_latency", 64'(doneA_cyc - startA), 64'd24);
        bad = (addrA_q.size() != 20);
        for (int i = 0; i < addrA_q.size(); i++) if (addrA_q[i] != i) bad = 1;
        chk("basic_addr_seq", 64'(bad), 64'd0);
        chk("basic_w0", 64'(wA(0)), 64'h1000);
        chk("basic_w19", 64'(wA(19)), 64'h1013);
        chk("basic_cnt", 64'(cntA), 64'd1);
        chk("basic_busy_after", 64'(busyA), 64'd0);

        // sync wait: sync raised 50 cycles after WAIT_SYNC entry
        for (int i = 0; i < 20; i++) mem[i] = 32'h2000 + i;
        syncA = 1'b0;
        prev = doneA_cnt;
        pulseA(10'd0);
        repeat (23) tick();
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (busyA !== 1'b1 || wA(0) !== 32'h1000 || doneA !== 1'b0) bad = 1;
            tick();
        end
        chk("wait_hold", 64'(bad), 64'd0);
        chk("wait_no_early_done", 64'(doneA_cnt - prev), 64'd0);
        syncA = 1'b1;
        tick();
        syncA = 1'b0;
        repeat (3) tick();
        chk("wait_done_once", 64'(doneA_cnt - prev), 64'd1);
        chk("wait_latency", 64'(doneA_cyc - startA), 64'd74);
        chk("wait_w0", 64'(wA(0)), 64'h2000);
        chk("wait_w19", 64'(wA(19)), 64'h2013);
        chk("wait_cnt", 64'(cntA), 64'd2);

        // ignored second start during READ
        for (int i = 0; i < 20; i++) mem[100 + i] = 32'h3000 + i;
        addrA_q.delete();
        syncA = 1'b1;
        prev = doneA_cnt;
        pulseA(10'd100);
        repeat (5) tick();
        pulseA(10'd300);
        for (int k = 0; k < 100 && doneA_cnt == prev; k++) tick();
        repeat (40) tick();
        chk("ign_done_once", 64'(doneA_cnt - prev), 64'd1);
        chk("ign_naddr", 64'(addrA_q.size()), 64'd20);
        if (addrA_q.size() == 20) begin
            chk("ign_addr_first", 64'(addrA_q[0]), 64'd100);
            chk("ign_addr_last", 64'(addrA_q[19]), 64'd119);
        end
        chk("ign_w7", 64'(wA(7)), 64'h3007);
        chk("ign_cnt", 64'(cntA), 64'd3);

        // reset mid-DRAIN, together with a load_start (reset wins)
        for (int i = 0; i < 20; i++) mem[200 + i] = 32'h4000 + i;
        prev = doneA_cnt;
        pulseA(10'd200);
        repeat (21) tick();
        chk("drain_busy_pre", 64'(busyA), 64'd1);
        rst = 1'b1; ldA = 1'b1;
        tick();
        rst = 1'b0; ldA = 1'b0;
        chk("drain_rst_busy", 64'(busyA), 64'd0);
        chk("drain_rst_coeffs", 64'(coeffsA == '0), 64'd1);
        chk("drain_rst_cnt", 64'(cntA), 64'd0);
        repeat (30) tick();
        chk("drain_no_done", 64'(doneA_cnt - prev), 64'd0);
        chk("drain_idle", 64'(busyA), 64'd0);
        pulseA(10'd200);
        wait_doneA("drain_reload_done", 100);
        chk("drain_reload_w0", 64'(wA(0)), 64'h4000);
        chk("drain_reload_w19", 64'(wA(19)), 64'h4013);
        chk("drain_reload_cnt", 64'(cntA), 64'd1);

        // write port never driven
        chk("write_safety", 64'(wviol), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
